fetch_instr_queue: RTL
======================

Name: fetch_instr_queue

Overview:
- Instruction queue between the fetch/realign stage and the decoder.
- Buffers fetched instructions with their PC, compressed/illegal flags and fetch-exception bit, in program order.
- Presents them one per cycle to the decoder through a valid/ready handshake.
- Decouples fetch stalls from decode back-pressure and drops all contents on a pipeline flush.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PC_W, 64, PC width.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridable).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush_i  in  1  drop all entries (branch mispredict / exception)
- fetch_valid_i  in  1  fetch entry offered
- fetch_ready_o  out  1  queue accepts entry this cycle
- fetch_pc_i  in  PC_W  PC of instruction
- fetch_instr_i  in  32  instruction (expanded if compressed)
- fetch_is_compressed_i  in  1  was compressed
- fetch_compressed_instr_i  in  16  original compressed encoding
- fetch_is_illegal_i  in  1  illegal compressed encoding
- fetch_ex_valid_i  in  1  fetch raised an exception
- dec_valid_o  out  1  head entry valid to decoder
- dec_ready_i  in  1  decoder consumes head
- dec_pc_o  out  PC_W  head PC
- dec_instr_o  out  32  head instruction
- dec_is_compressed_o  out  1  head compressed flag
- dec_compressed_instr_o  out  16  head compressed encoding
- dec_is_illegal_o  out  1  head illegal flag
- dec_ex_valid_o  out  1  head exception flag
- count_o  out  CNT_W  current occupancy

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries.
  - Read pointer and write pointer, each $clog2(DEPTH) bits, wrap naturally modulo DEPTH.
  - Occupancy counter of CNT_W bits.
- Reset (reset_n low, asynchronous): pointers=0, count=0, dec_valid_o=0, fetch_ready_o=1 once reset deasserts. All dec_*_o data outputs read 0 (entry storage cleared).
- Push: fetch_valid_i && fetch_ready_o && !flush_i. Entry written at the write pointer on the rising edge; write pointer +1.
- Pop: dec_valid_o && dec_ready_i && !flush_i. Read pointer +1.
- fetch_ready_o = (count != DEPTH).
  - Registered-state function only; no combinational path from dec_ready_i.
  - When full, a same-cycle pop does not enable a push.
- dec_valid_o = (count != 0), unless the optional feature applies.
- dec_*_o: combinational read of the entry at the read pointer. Stable while dec_valid_o && !dec_ready_i (no change until the handshake completes).
- Latency: an entry pushed in cycle N is visible on dec_* in cycle N+1.
- Simultaneous push and pop, count not 0 and not DEPTH: count unchanged, both pointers advance.
- Flush: flush_i in cycle N gives count=0 and both pointers=0 at N+1.
  - Any push or pop in cycle N is ignored.
  - dec_valid_o=0 and fetch_ready_o=1 at N+1.
  - Flush takes priority over push and pop.
- Empty pop (dec_ready_i with dec_valid_o=0): no effect. Full push attempt: not accepted (fetch_ready_o=0); the entry must be held by the source.
- Count never exceeds DEPTH and never underflows. Both conditions are checked by embedded assertions guarded by reset_n.
- Reset mid-operation: all entries discarded immediately; no partial entry survives.

Optional Feature:
- Macro: FETCH_QUEUE_FALLTHROUGH_EN.
- Defined:
  - When count==0 && fetch_valid_i && !flush_i, dec_valid_o=1 and dec_*_o are driven directly from fetch_*_i in the same cycle.
  - If dec_ready_i is also 1, the entry is consumed without being written: pointers and count unchanged.
  - Otherwise it is written normally.
  - Zero-latency path when empty.
- Undefined: no bypass; minimum latency 1 cycle as above.

Test Plan:
- Reset, then push PCs 0x1000, 0x1004, 0x1008 (instr 0x00A00093, 0x00B00113, 0x00C00193) with dec_ready_i=0 -> count_o=3, dec_pc_o=0x1000. Then dec_ready_i=1 for 3 cycles -> 0x1000, 0x1004, 0x1008 in order, count_o=0, dec_valid_o=0.
- Fill DEPTH=4 with dec_ready_i=0 -> fetch_ready_o=0 after the 4th push. A 5th entry held on fetch_valid_i is not accepted. One pop -> fetch_ready_o=1 next cycle; the 5th entry is accepted and wraps to slot 0.
- count_o=2, push and pop every cycle for 10 cycles -> count_o stays 2 and output order matches input order across pointer wrap.
- count_o=3, flush_i=1 together with fetch_valid_i=1 and dec_ready_i=1 -> next cycle count_o=0, dec_valid_o=0, fetch_ready_o=1, pushed entry absent.
- Compressed entry (fetch_is_compressed_i=1, compressed_instr 0x4501, instr 0x00000513, ex_valid=1) -> dec_* fields reproduce all values exactly, including dec_ex_valid_o=1.
- Empty queue, push with dec_ready_i=1 -> without FETCH_QUEUE_FALLTHROUGH_EN: dec_valid_o=1 one cycle later. With it: dec_valid_o=1 same cycle and count_o stays 0.

Source files
------------

// File: rtl/fetch_instr_queue_if.sv
// Fetch -> queue -> decode bus for fetch_instr_queue. The "master" side is the
// fetch/decoder environment; the "slave" side is the queue.
interface fetch_instr_queue_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 64
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Valid/ready semantics on both sides: a transfer happens on a rising edge
    // where valid && ready && !flush_i; valid and its payload must hold until
    // that transfer, and ready never depends combinationally on valid.
    logic              flush_i;
    logic              fetch_valid_i;
    logic              fetch_ready_o;
    logic [PC_W-1:0]   fetch_pc_i;
    logic [31:0]       fetch_instr_i;
    logic              fetch_is_compressed_i;
    logic [15:0]       fetch_compressed_instr_i;
    logic              fetch_is_illegal_i;
    logic              fetch_ex_valid_i;
    logic              dec_valid_o;
    logic              dec_ready_i;
    logic [PC_W-1:0]   dec_pc_o;
    logic [31:0]       dec_instr_o;
    logic              dec_is_compressed_o;
    logic [15:0]       dec_compressed_instr_o;
    logic              dec_is_illegal_o;
    logic              dec_ex_valid_o;
    logic [CNT_W-1:0]  count_o;

    modport master (
        output flush_i, fetch_valid_i, fetch_pc_i, fetch_instr_i, fetch_is_compressed_i,
               fetch_compressed_instr_i, fetch_is_illegal_i, fetch_ex_valid_i, dec_ready_i,
        input  fetch_ready_o, dec_valid_o, dec_pc_o, dec_instr_o, dec_is_compressed_o,
               dec_compressed_instr_o, dec_is_illegal_o, dec_ex_valid_o, count_o
    );

    modport slave (
        input  flush_i, fetch_valid_i, fetch_pc_i, fetch_instr_i, fetch_is_compressed_i,
               fetch_compressed_instr_i, fetch_is_illegal_i, fetch_ex_valid_i, dec_ready_i,
        output fetch_ready_o, dec_valid_o, dec_pc_o, dec_instr_o, dec_is_compressed_o,
               dec_compressed_instr_o, dec_is_illegal_o, dec_ex_valid_o, count_o
    );
endinterface

// File: rtl/fetch_instr_queue.sv
// Circular instruction queue between fetch/realign and decode, flushable.
// Optional macro FETCH_QUEUE_FALLTHROUGH_EN: zero-latency bypass when the queue is empty.
module fetch_instr_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 64
) (
    input logic               clk,
    input logic               reset_n,
    fetch_instr_queue_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic            is_compressed;
        logic [15:0]     compressed_instr;
        logic            is_illegal;
        logic            ex_valid;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           in_entry;
    entry_t           out_entry;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CNT_W-1:0] count;
    logic             not_empty;
    logic             bypass;
    logic             push;
    logic             pop;

    assign in_entry = '{pc:               bus.fetch_pc_i,
                        instr:            bus.fetch_instr_i,
                        is_compressed:    bus.fetch_is_compressed_i,
                        compressed_instr: bus.fetch_compressed_instr_i,
                        is_illegal:       bus.fetch_is_illegal_i,
                        ex_valid:         bus.fetch_ex_valid_i};

    assign not_empty = (count != '0);

`ifdef FETCH_QUEUE_FALLTHROUGH_EN
    assign bypass = !not_empty && bus.fetch_valid_i && !bus.flush_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry taken by the decoder in the same cycle is never stored.
    assign push = bus.fetch_valid_i && (count != FULL) && !bus.flush_i
                  && !(bypass && bus.dec_ready_i);
    assign pop  = not_empty && bus.dec_ready_i && !bus.flush_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign out_entry = bypass ? in_entry : mem[rd_ptr];

    assign bus.fetch_ready_o          = (count != FULL);
    assign bus.dec_valid_o            = not_empty || bypass;
    assign bus.dec_pc_o               = out_entry.pc;
    assign bus.dec_instr_o            = out_entry.instr;
    assign bus.dec_is_compressed_o    = out_entry.is_compressed;
    assign bus.dec_compressed_instr_o = out_entry.compressed_instr;
    assign bus.dec_is_illegal_o       = out_entry.is_illegal;
    assign bus.dec_ex_valid_o         = out_entry.ex_valid;
    assign bus.count_o                = count;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) count <= FULL);
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n) !(pop && count == '0));
    a_no_full_push: assert property (@(posedge clk) disable iff (!reset_n) !(push && count == FULL));
endmodule
